// File: rtl/fetch_ctrl.sv
// Instruction-fetch control: owns the PC, predicts B-type branches with a 16-entry
// 2-bit counter table, treats JAL as always taken, and applies redirect/stall/halt.
`timescale 1ns/1ps

module fetch_ctrl (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [31:0] imemData_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [11:0] redirectPc_i,
  input  logic        bhtUpdate_i,
  input  logic [11:0] bhtUpdatePc_i,
  input  logic        bhtTaken_i,
  input  logic        halt_i,
  output logic [11:0] imemAddr_o,
  output logic [11:0] pc_o,
  output logic [31:0] branchPc_o,
  output logic        bpr_o,
  output logic        flush_o,
  output logic        latchn_o,
  output logic        halted_o
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t      state, state_next;
  logic [11:0] pc_r, pc_next;
  logic [1:0]  bht [0:15];

  logic [6:0]  op;
  logic        is_branch, is_jal;
  logic [12:0] b_imm;
  logic [20:0] j_imm;
  logic [31:0] imm_ext, target;
  logic [3:0]  rd_idx, wr_idx;
  logic [1:0]  rd_cnt, wr_cnt;
  logic        predict_taken;
  logic        flush, latchn, bpr;
  logic [31:0] branch_pc;
  logic [27:0] unused_bits;

  assign op        = imemData_i[6:0];
  assign is_branch = (op == OP_BRANCH);
  assign is_jal    = (op == OP_JAL);
  assign b_imm     = {imemData_i[31], imemData_i[7], imemData_i[30:25], imemData_i[11:8], 1'b0};
  assign j_imm     = {imemData_i[31], imemData_i[19:12], imemData_i[20], imemData_i[30:21], 1'b0};

  always_comb begin
    imm_ext = 32'd0;
    if (is_jal)
      imm_ext = {{11{j_imm[20]}}, j_imm};
    else if (is_branch)
      imm_ext = {{19{b_imm[12]}}, b_imm};
  end

  assign target = {20'd0, pc_r} + imm_ext;

  // The prediction reads the counter before any same-edge update lands.
  assign rd_idx        = pc_r[5:2];
  assign rd_cnt        = bht[rd_idx];
  assign predict_taken = is_jal | (is_branch & rd_cnt[1]);

  assign wr_idx = bhtUpdatePc_i[5:2];
  assign wr_cnt = bht[wr_idx];

  assign unused_bits = {bhtUpdatePc_i[11:6], bhtUpdatePc_i[1:0], target[31:12]};

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= BOOT;
      pc_r  <= 12'd0;
    end else begin
      state <= state_next;
      pc_r  <= pc_next;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 16; i++)
        bht[i] <= 2'b01;
    end else if (bhtUpdate_i && (state != HALT)) begin
      if (bhtTaken_i && (wr_cnt != 2'b11))
        bht[wr_idx] <= wr_cnt + 2'd1;
      else if (!bhtTaken_i && (wr_cnt != 2'b00))
        bht[wr_idx] <= wr_cnt - 2'd1;
    end
  end

  // Defaults describe a bubble with the PC held; only RUN fetches real work.
  always_comb begin
    state_next = state;
    pc_next    = pc_r;
    flush      = 1'b1;
    latchn     = 1'b0;
    bpr        = 1'b0;
    branch_pc  = 32'd0;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (halt_i) begin
          state_next = HALT;
        end else if (redirect_i) begin
          pc_next = redirectPc_i;
        end else if (stall_i) begin
          flush  = 1'b0;
          latchn = 1'b1;
        end else begin
          flush = 1'b0;
          if (predict_taken) begin
            pc_next = target[11:0];
            bpr     = 1'b1;
          end else begin
            pc_next = pc_r + 12'd4;
          end
          branch_pc = {20'd0, pc_next};
        end
      end
      HALT: state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  assign imemAddr_o = pc_r;
  assign pc_o       = pc_r;
  assign branchPc_o = branch_pc;
  assign bpr_o      = bpr;
  assign flush_o    = flush;
  assign latchn_o   = latchn;
  assign halted_o   = (state == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random traffic
// compared against an arithmetic reference model of the fetch rules.
`timescale 1ns/1ps

module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b1;
  logic [31:0] imemData_i = NOP;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [11:0] redirectPc_i = 12'd0;
  logic        bhtUpdate_i = 1'b0;
  logic [11:0] bhtUpdatePc_i = 12'd0;
  logic        bhtTaken_i = 1'b0;
  logic        halt_i = 1'b0;
  logic [11:0] imemAddr_o;
  logic [11:0] pc_o;
  logic [31:0] branchPc_o;
  logic        bpr_o;
  logic        flush_o;
  logic        latchn_o;
  logic        halted_o;

  int total = 0;
  int bad = 0;

  // Reference model: phase 0 = boot cycle, 1 = running, 2 = halted
  int m_pc;
  int m_phase;
  int m_bht [16];

  always #5 CLK = ~CLK;

  fetch_ctrl dut (
    .CLK(CLK), .RSTn(RSTn), .imemData_i(imemData_i), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirectPc_i(redirectPc_i), .bhtUpdate_i(bhtUpdate_i),
    .bhtUpdatePc_i(bhtUpdatePc_i), .bhtTaken_i(bhtTaken_i), .halt_i(halt_i),
    .imemAddr_o(imemAddr_o), .pc_o(pc_o), .branchPc_o(branchPc_o), .bpr_o(bpr_o),
    .flush_o(flush_o), .latchn_o(latchn_o), .halted_o(halted_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int boff(input logic [31:0] i);
    int v;
    v = i[31] ? -4096 : 0;
    v += int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
    return v;
  endfunction

  function automatic int joff(input logic [31:0] i);
    int v;
    v = i[31] ? -(1 << 20) : 0;
    v += int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
    return v;
  endfunction

  function automatic logic [31:0] enc_b(input int off);
    logic [12:0] o;
    o = off[12:0];
    return {o[12], o[10:5], 5'd2, 5'd1, 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(input int off);
    logic [20:0] j;
    j = off[20:0];
    return {j[20], j[10:1], j[11], j[19:12], 5'd1, 7'b1101111};
  endfunction

  task automatic modelReset();
    m_pc = 0;
    m_phase = 0;
    for (int k = 0; k < 16; k++) m_bht[k] = 1;
  endtask

  task automatic checkReset(input string tag);
    check({tag, "_imemAddr"}, imemAddr_o, 0);
    check({tag, "_pc"}, pc_o, 0);
    check({tag, "_flush"}, flush_o, 1);
    check({tag, "_latchn"}, latchn_o, 0);
    check({tag, "_bpr"}, bpr_o, 0);
    check({tag, "_branchPc"}, branchPc_o, 0);
    check({tag, "_halted"}, halted_o, 0);
  endtask

  task automatic checkOutput(input logic [31:0] instr, input bit st, input bit rd,
                             input int rpc, input bit hl, output int npc, output int nph);
    int  op;
    bit  isb, isj, pred;
    int  off;
    npc = m_pc;
    nph = m_phase;
    check("imemAddr", imemAddr_o, m_pc);
    check("pc", pc_o, m_pc);
    check("halted", halted_o, (m_phase == 2));
    if (m_phase == 0) begin
      check("boot_flush", flush_o, 1);
      check("boot_latchn", latchn_o, 0);
      nph = 1;
    end else if (m_phase == 2) begin
      check("halt_flush", flush_o, 1);
      check("halt_latchn", latchn_o, 0);
    end else begin
      op   = int'(instr[6:0]);
      isb  = (op == 'h63);
      isj  = (op == 'h6F);
      off  = isb ? boff(instr) : (isj ? joff(instr) : 0);
      pred = isj || (isb && m_bht[(m_pc / 4) % 16] >= 2);
      if (hl) begin
        check("halt_branchPc", branchPc_o, 0);
        nph = 2;
      end else if (rd) begin
        check("redir_flush", flush_o, 1);
        check("redir_latchn", latchn_o, 0);
        check("redir_branchPc", branchPc_o, 0);
        npc = rpc & 'hFFF;
      end else if (st) begin
        check("stall_latchn", latchn_o, 1);
        check("stall_flush", flush_o, 0);
      end else begin
        npc = pred ? ((m_pc + off) & 'hFFF) : ((m_pc + 4) % 4096);
        check("bpr", bpr_o, pred);
        check("branchPc", branchPc_o, npc);
        check("run_flush", flush_o, 0);
        check("run_latchn", latchn_o, 0);
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input bit st, input bit rd, input int rpc,
                               input bit upd, input int upc, input bit tkn, input bit hl);
    int npc, nph, idx;
    imemData_i    = instr;
    stall_i       = st;
    redirect_i    = rd;
    redirectPc_i  = rpc[11:0];
    bhtUpdate_i   = upd;
    bhtUpdatePc_i = upc[11:0];
    bhtTaken_i    = tkn;
    halt_i        = hl;
    #1;
    checkOutput(instr, st, rd, rpc, hl, npc, nph);
    @(posedge CLK);
    if (upd && m_phase != 2) begin
      idx = (upc / 4) % 16;
      if (tkn && m_bht[idx] < 3) m_bht[idx]++;
      else if (!tkn && m_bht[idx] > 0) m_bht[idx]--;
    end
    m_pc = npc;
    m_phase = nph;
    #1;
  endtask

  initial begin
    logic [31:0] instr;
    int kind;
    #2 RSTn = 1'b0;
    #1 checkReset("reset");
    modelReset();
    @(posedge CLK);
    @(posedge CLK);
    #1 RSTn = 1'b1;

    // Boot then sequential NOPs: 0, 4, 8
    for (int k = 0; k < 4; k++) applyStimulus(NOP, 0, 0, 0, 0, 0, 0, 0);
    check("seq_pc_12", pc_o, 'h00C);

    applyStimulus(NOP, 0, 1, 'hFFC, 0, 0, 0, 0);
    applyStimulus(NOP, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_pc", pc_o, 'h000);

    applyStimulus(NOP, 0, 1, 'h010, 0, 0, 0, 0);
    applyStimulus(enc_jal('h20), 0, 0, 0, 0, 0, 0, 0);
    check("jal_dest", pc_o, 'h030);

    applyStimulus(NOP, 0, 1, 'h040, 0, 0, 0, 0);
    applyStimulus(enc_b(-8), 0, 0, 0, 0, 0, 0, 0);
    check("beq_reset_nt", pc_o, 'h044);

    applyStimulus(NOP, 0, 1, 'h040, 1, 'h040, 1, 0);
    applyStimulus(enc_b(-8), 0, 0, 0, 0, 0, 0, 0);
    check("beq_taken", pc_o, 'h038);

    for (int k = 0; k < 4; k++) applyStimulus(NOP, 0, 0, 0, 1, 'h040, 0, 0);
    applyStimulus(NOP, 0, 0, 0, 1, 'h040, 1, 0);
    applyStimulus(NOP, 0, 1, 'h040, 0, 0, 0, 0);
    applyStimulus(enc_b(-8), 0, 0, 0, 0, 0, 0, 0);
    check("beq_weak_nt", pc_o, 'h044);

    applyStimulus(NOP, 1, 1, 'h100, 0, 0, 0, 0);
    check("stall_redir_pc", pc_o, 'h100);

    for (int k = 0; k < 3; k++) applyStimulus(NOP, 1, 0, 0, 0, 0, 0, 0);
    check("stall_hold_pc", pc_o, 'h100);

    // Random traffic, including same-cycle update/read of a counter
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: instr = NOP;
        1: instr = enc_b((int'($urandom_range(0, 4095)) - 2048) * 2);
        2: instr = enc_jal((int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2);
        default: instr = $urandom;
      endcase
      applyStimulus(instr, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                    int'($urandom_range(0, 1023)) * 4, ($urandom_range(0, 1) == 1),
                    int'($urandom_range(0, 4095)), ($urandom_range(0, 1) == 1), 0);
    end

    applyStimulus(NOP, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++)
      applyStimulus(enc_jal(64), k[0], 1, 'h200, 1, 'h040, 1, 0);

    #2 RSTn = 1'b0;
    #1 checkReset("halt_reset");
    modelReset();
    @(posedge CLK);
    #1 RSTn = 1'b1;
    for (int k = 0; k < 3; k++) applyStimulus(NOP, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch control block. It owns the program counter and drives the instruction-memory address. It also produces the write side of the IF/ID pipeline register: `pc`, `branchPc`, `bpr`, `flush` and `latchn`. It predicts B-type branches with a 16-entry table of 2-bit saturating counters, always predicts JAL as taken, and applies redirects from EX, stalls from the hazard unit and halt from WB.

## Interface
- No parameters.
- `CLK`  in  1  clock; all state updates on posedge.
- `RSTn`  in  1  asynchronous active-low reset.
- `imemData_i`  in  32  instruction at `imemAddr_o`; combinational read, same cycle.
- `stall_i`  in  1  hazard-unit stall request; hold PC and IF/ID.
- `redirect_i`  in  1  EX mispredict or jump correction.
- `redirectPc_i`  in  12  corrected PC, valid with `redirect_i`.
- `bhtUpdate_i`  in  1  a resolved B-type instruction is in EX.
- `bhtUpdatePc_i`  in  12  PC of the resolved branch.
- `bhtTaken_i`  in  1  actual outcome of the resolved branch.
- `halt_i`  in  1  halt committed in WB.
- `imemAddr_o`  out  12  equals `pc_r`.
- `pc_o`  out  12  PC of the instruction currently fetched.
- `branchPc_o`  out  32  next PC chosen by fetch, zero-extended; 0 when `flush_o`=1.
- `bpr_o`  out  1  fetch predicted taken (B-type counter ≥2, or JAL).
- `flush_o`  out  1  the IF/ID entry written this cycle is a bubble.
- `latchn_o`  out  1  active-low IF/ID write enable.
- `halted_o`  out  1  state is HALT.

## Operation
- State: `pc_r[11:0]`, FSM {BOOT, RUN, HALT}, `bht[0:15]` of 2-bit counters indexed by `pc[5:2]`.
- Reset (async): `pc_r`=0, state=BOOT, every counter=2'b01.
- Reset output values: `imemAddr_o`=0, `pc_o`=0, `flush_o`=1, `latchn_o`=0, `bpr_o`=0, `branchPc_o`=0, `halted_o`=0.
- BOOT: lasts one cycle. Outputs `flush_o`=1, `latchn_o`=0, `pc_r` unchanged, next state RUN.
- Decode in RUN, with `op` = `imemData_i[6:0]`:
  - B-type when `op`=1100011. Immediate is {i[31],i[7],i[30:25],i[11:8],0}, sign-extended from 13 bits.
  - JAL when `op`=1101111. Immediate is {i[31],i[19:12],i[20],i[30:21],0}, sign-extended from 21 bits.
- Target is {20'b0,`pc_r`} + sext(imm), computed in 32 bits. The PC loads `target[11:0]`.
- Next-PC priority in RUN:
  1. `halt_i`: next state HALT, PC holds.
  2. `redirect_i`: PC ← `redirectPc_i`; `flush_o`=1; `latchn_o`=0.
  3. `stall_i`: PC holds; `latchn_o`=1; `flush_o`=0.
  4. Predicted taken: PC ← `target[11:0]`; `bpr_o`=1.
  5. Otherwise: PC ← `pc_r`+4, wrapping modulo 4096; `bpr_o`=0.
- `branchPc_o` follows cases 4 and 5: {20'b0, next PC}. It is 0 in cases 1 and 2.
- HALT is terminal until reset. PC holds; `flush_o`=1; `latchn_o`=0, so the IF/ID register fills with bubbles; `halted_o`=1. Inputs are ignored except `RSTn`.
- BHT update is applied on posedge when `bhtUpdate_i`=1, in every state except HALT:
  - Index is `bhtUpdatePc_i[5:2]`.
  - Taken: counter+1, saturating at 3. Not taken: counter−1, saturating at 0.
- The update is independent of stall and redirect.

## Timing
- Fetch-to-IF/ID latency: 1 cycle. `pc_o`, `bpr_o`, `branchPc_o` and `flush_o` are combinational from `pc_r`, state and `imemData_i`, and are captured by IF/ID at the next posedge.
- Redirect takes effect at the posedge after `redirect_i` is sampled high. The next cycle fetches `redirectPc_i`.
- Redirect and stall in the same cycle: redirect wins. `latchn_o`=0 and `flush_o`=1.
- Redirect and halt in the same cycle: halt wins.
- BHT read-during-write to the same index: the prediction uses the old counter value. The new value is visible next cycle.
- `RSTn` asserted mid-operation, in any state: all state returns to reset values immediately. BOOT is re-entered on the first posedge after release.

## Test plan
- Reset release: the first cycle shows `flush_o`=1 and `pc_o`=0. Over the next three cycles with NOPs, `pc_o` = 0, 4, 8 and `flush_o`=0.
- Wrap: from `pc_r`=0xFFC fetching a NOP, the next `pc_o` is 0x000.
- JAL at PC 0x010 with imm=+0x20: `bpr_o`=1 and `branchPc_o`=0x30. The next `pc_o` is 0x030.
- BEQ at PC 0x040 with imm=−8:
  - At reset, `bpr_o`=0 and `branchPc_o`=0x44.
  - After one `bhtUpdate_i` taken for 0x040, `bpr_o`=1 and the next `pc_o` is 0x038.
  - After four further not-taken updates, the counter is 0. One taken update then gives 1 and still predicts not-taken.
- `stall_i`=1 and `redirect_i`=1 with `redirectPc_i`=0x100 in the same cycle: `latchn_o`=0 and `flush_o`=1. The next `pc_o` is 0x100.
- `stall_i` alone for 3 cycles: `latchn_o`=1 and `pc_o` is constant.
- `halt_i` pulse: from the next cycle on, `halted_o`=1, `flush_o`=1 and PC is frozen, including under `redirect_i`. Dropping `RSTn` mid-HALT returns outputs to reset values asynchronously.
